noc_ingress_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the single NSU ingress flit port (`noc2axi_data` / `s_is_head` / `s_is_tail` / `nsu_busy`) between `PORT_NUM` flit sources, such as NMU-side virtual channels or local generators. It sits directly in front of the NSU. It grants one source per packet, from the head flit to the tail flit, and never interleaves flits of different packets. It also honours `nsu_busy` backpressure and flags protocol violations on its inputs.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/noc_rr_pick.sv | 31 +++
 rtl/noc_ingress_arbiter.sv | 149 ++++++++++++++
 tb/tb_noc_ingress_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, head/tail marker codes, field widths,
// the ingress arbiter state encoding and a round-robin index helper.
package noc_pkg;

    localparam int unsigned TYPE_W = 2;
    localparam int unsigned CODE_W = 2;

    localparam logic [TYPE_W-1:0] TYPE_WRITE   = 2'd0;
    localparam logic [TYPE_W-1:0] TYPE_RD_REQ  = 2'd1;
    localparam logic [TYPE_W-1:0] TYPE_BRESP   = 2'd2;
    localparam logic [TYPE_W-1:0] TYPE_RD_DATA = 2'd3;

    localparam logic [CODE_W-1:0] CODE_BODY   = 2'b00;
    localparam logic [CODE_W-1:0] CODE_TAIL   = 2'b01;
    localparam logic [CODE_W-1:0] CODE_HEAD   = 2'b10;
    localparam logic [CODE_W-1:0] CODE_SINGLE = 2'b11;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_e;

    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first set request after last_id, wrapping
// modulo PORT_NUM. Shared by the ingress and egress arbiters.
module noc_rr_pick
    import noc_pkg::*;
#(
    parameter int unsigned PORT_NUM = 4
) (
    input  logic [PORT_NUM-1:0]         req,
    input  logic [$clog2(PORT_NUM)-1:0] last_id,
    output logic [$clog2(PORT_NUM)-1:0] grant_id,
    output logic                        any
);

    localparam int unsigned IDX_W = $clog2(PORT_NUM);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_id = '0;
        any      = 1'b0;
        cand     = '0;
        for (int unsigned off = 1; off <= PORT_NUM; off++) begin
            cand = IDX_W'(rr_index(32'(last_id), off, PORT_NUM));
            if (!any && req[cand]) begin
                any      = 1'b1;
                grant_id = cand;
            end
        end
    end

endmodule

// File: rtl/noc_ingress_arbiter.sv
// Packet-atomic round-robin arbiter in front of the NSU ingress flit port:
// one source owns the port from head to tail, with busy backpressure and error flags.
module noc_ingress_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned PORT_NUM     = 4,
    parameter int unsigned FLIT_NUM_MAX = 16
) (
    input  logic                             noc_clk,
    input  logic                             noc_rst,
    input  logic [PORT_NUM-1:0]              req_valid,
    input  logic [PORT_NUM*DATA_WIDTH-1:0]   req_data,
    input  logic [PORT_NUM-1:0]              req_head,
    input  logic [PORT_NUM-1:0]              req_tail,
    output logic [PORT_NUM-1:0]              req_ready,
    output logic [DATA_WIDTH:0]              noc2axi_data,
    output logic                             s_is_head,
    output logic                             s_is_tail,
    input  logic                             nsu_busy,
    output logic                             grant_vld,
    output logic [$clog2(PORT_NUM)-1:0]      grant_id,
    output logic                             err_orphan,
    output logic                             err_overlong
);

    localparam int unsigned IDX_W = $clog2(PORT_NUM);
    localparam int unsigned CNT_W = $clog2(FLIT_NUM_MAX + 3);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FLIT_NUM_MAX + 2);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    last_id_q, last_id_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic                grant_vld_q, grant_vld_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH:0] data_q, data_d;
    logic                head_q, head_d;
    logic                tail_q, tail_d;
    logic                err_orphan_q, err_orphan_d;
    logic                err_overlong_q, err_overlong_d;

    logic [PORT_NUM-1:0]   eligible;
    logic [PORT_NUM-1:0]   owner_mask;
    logic [IDX_W-1:0]      pick_id;
    logic                  pick_any;
    logic                  accept;
    logic                  own_head;
    logic                  own_tail;
    logic [DATA_WIDTH-1:0] own_flit;
    logic [CNT_W-1:0]      cnt_inc;

    noc_rr_pick #(
        .PORT_NUM(PORT_NUM)
    ) u_pick (
        .req     (eligible),
        .last_id (last_id_q),
        .grant_id(pick_id),
        .any     (pick_any)
    );

    always_comb begin
        eligible   = req_valid & req_head;
        owner_mask = '0;
        if (state_q == ARB_XFER) begin
            owner_mask[grant_id_q] = 1'b1;
        end
        req_ready = owner_mask & {PORT_NUM{~nsu_busy}};
        accept    = |(req_ready & req_valid);
        own_head  = req_head[grant_id_q];
        own_tail  = req_tail[grant_id_q];
        own_flit  = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        // Saturate so an overlong packet cannot wrap the counter and hide itself.
        cnt_inc   = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + 1'b1;

        state_d        = state_q;
        last_id_d      = last_id_q;
        grant_id_d     = grant_id_q;
        grant_vld_d    = grant_vld_q;
        cnt_d          = cnt_q;
        data_d         = '0;
        head_d         = 1'b0;
        tail_d         = 1'b0;
        err_orphan_d   = err_orphan_q | (|(req_valid & ~req_head & ~owner_mask));
        err_overlong_d = err_overlong_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d     = ARB_XFER;
                    grant_id_d  = pick_id;
                    grant_vld_d = 1'b1;
                    last_id_d   = pick_id;
                end
            end
            ARB_XFER: begin
                if (accept) begin
                    data_d = {1'b1, own_flit};
                    head_d = own_head;
                    tail_d = own_tail;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == CNT_LIMIT && !own_tail) begin
                        err_overlong_d = 1'b1;
                    end
                    if (own_tail) begin
                        state_d     = ARB_IDLE;
                        grant_vld_d = 1'b0;
                        cnt_d       = '0;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q        <= ARB_IDLE;
            last_id_q      <= IDX_W'(PORT_NUM - 1);
            grant_id_q     <= '0;
            grant_vld_q    <= 1'b0;
            cnt_q          <= '0;
            data_q         <= '0;
            head_q         <= 1'b0;
            tail_q         <= 1'b0;
            err_orphan_q   <= 1'b0;
            err_overlong_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_id_q      <= last_id_d;
            grant_id_q     <= grant_id_d;
            grant_vld_q    <= grant_vld_d;
            cnt_q          <= cnt_d;
            data_q         <= data_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            err_orphan_q   <= err_orphan_d;
            err_overlong_q <= err_overlong_d;
        end
    end

    assign noc2axi_data = data_q;
    assign s_is_head    = head_q;
    assign s_is_tail    = tail_q;
    assign grant_vld    = grant_vld_q;
    assign grant_id     = grant_id_q;
    assign err_orphan   = err_orphan_q;
    assign err_overlong = err_overlong_q;

endmodule

// File: tb/tb_noc_ingress_arbiter.sv
// Self-checking bench for noc_ingress_arbiter: directed packet scenarios plus
// randomized traffic against a packet-level reference model.
module tb_noc_ingress_arbiter;
    import noc_pkg::*;

    localparam int DW = 128;
    localparam int PN = 4;
    localparam int FM = 16;
    localparam int IW = $clog2(PN);

    typedef logic [DW:0] word_t;

    logic               noc_clk;
    logic               noc_rst;
    logic [PN-1:0]      req_valid;
    logic [PN*DW-1:0]   req_data;
    logic [PN-1:0]      req_head;
    logic [PN-1:0]      req_tail;
    logic [PN-1:0]      req_ready;
    logic [DW:0]        noc2axi_data;
    logic               s_is_head;
    logic               s_is_tail;
    logic               nsu_busy;
    logic               grant_vld;
    logic [IW-1:0]      grant_id;
    logic               err_orphan;
    logic               err_overlong;

    noc_ingress_arbiter #(
        .DATA_WIDTH  (DW),
        .PORT_NUM    (PN),
        .FLIT_NUM_MAX(FM)
    ) dut (
        .noc_clk     (noc_clk),
        .noc_rst     (noc_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_head    (req_head),
        .req_tail    (req_tail),
        .req_ready   (req_ready),
        .noc2axi_data(noc2axi_data),
        .s_is_head   (s_is_head),
        .s_is_tail   (s_is_tail),
        .nsu_busy    (nsu_busy),
        .grant_vld   (grant_vld),
        .grant_id    (grant_id),
        .err_orphan  (err_orphan),
        .err_overlong(err_overlong)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;

    task automatic check_eq(input string tag, input word_t got, input word_t exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sources: one packet per port at a time, length in flits, current flit index.
    int  src_len [PN];
    int  src_idx [PN];
    int  src_pkt [PN];
    bit  force_orphan;
    int  busy_mode;
    bit  valid_rand;
    bit  pkt_rand;
    bit  rst_drv;

    // Reference model: owner port (-1 = none), rotation pointer, flits in packet.
    int    m_owner;
    int    m_last;
    int    m_gid;
    int    m_cnt;
    bit    m_orphan;
    bit    m_overlong;
    word_t e_data;
    bit    e_head;
    bit    e_tail;

    // Output stream tracking, decoded from the flit payload itself.
    int out_cnt;
    int n_out;
    int head_log[$];

    function automatic logic [TYPE_W-1:0] pkt_type(input int pk);
        case (pk % 4)
            0:       return TYPE_WRITE;
            1:       return TYPE_RD_REQ;
            2:       return TYPE_BRESP;
            default: return TYPE_RD_DATA;
        endcase
    endfunction

    function automatic logic [DW-1:0] mk_flit(input int p, input int len, input int idx, input int pk);
        logic [DW-1:0]     f;
        logic [CODE_W-1:0] code;
        if (idx == 0 && idx == len - 1) code = CODE_SINGLE;
        else if (idx == 0)              code = CODE_HEAD;
        else if (idx == len - 1)        code = CODE_TAIL;
        else                            code = CODE_BODY;
        f = '0;
        f[DW-1 -: 8]          = 8'(p);
        f[DW-9 -: 8]          = 8'(len);
        f[DW-17 -: 8]         = 8'(idx);
        f[DW-25 -: 16]        = 16'(pk);
        f[TYPE_W-1:0]         = pkt_type(pk);
        f[TYPE_W +: CODE_W]   = code;
        return f;
    endfunction

    task automatic reset_model();
        m_owner    = -1;
        m_last     = PN - 1;
        m_gid      = 0;
        m_cnt      = 0;
        m_orphan   = 1'b0;
        m_overlong = 1'b0;
        e_data     = '0;
        e_head     = 1'b0;
        e_tail     = 1'b0;
        out_cnt    = 0;
    endtask

    // One clock cycle, entered and left on the falling edge.
    task automatic step();
        logic [PN-1:0]     exp_ready;
        logic [PN-1:0]     hs;
        logic [DW-1:0]     f;
        logic [CODE_W-1:0] code;
        int                own;
        int                win;

        check_eq("out_data", noc2axi_data, e_data);
        check_eq("out_head", word_t'(s_is_head), word_t'(e_head));
        check_eq("out_tail", word_t'(s_is_tail), word_t'(e_tail));
        check_eq("grant_vld", word_t'(grant_vld), word_t'(m_owner >= 0));
        check_eq("grant_id", word_t'(grant_id), word_t'(m_gid));
        check_eq("err_orphan", word_t'(err_orphan), word_t'(m_orphan));
        check_eq("err_overlong", word_t'(err_overlong), word_t'(m_overlong));

        if (noc2axi_data[DW] === 1'b1) begin
            f    = noc2axi_data[DW-1:0];
            code = f[TYPE_W +: CODE_W];
            check_eq("seq_idx", word_t'(f[DW-17 -: 8]), word_t'(out_cnt));
            check_eq("code_head", word_t'(s_is_head), word_t'(code == CODE_HEAD || code == CODE_SINGLE));
            check_eq("code_tail", word_t'(s_is_tail), word_t'(code == CODE_TAIL || code == CODE_SINGLE));
            if (s_is_head) head_log.push_back(int'(f[DW-1 -: 8]));
            out_cnt = s_is_tail ? 0 : out_cnt + 1;
            n_out++;
        end

        noc_rst   = rst_drv;
        case (busy_mode)
            0:       nsu_busy = 1'b0;
            1:       nsu_busy = 1'b1;
            default: nsu_busy = ($urandom_range(3) == 0);
        endcase
        req_valid = '0;
        req_head  = '0;
        req_tail  = '0;
        req_data  = '0;
        for (int p = 0; p < PN; p++) begin
            if (src_len[p] > 0 && (!valid_rand || $urandom_range(3) != 0)) begin
                req_valid[p]           = 1'b1;
                req_head[p]            = (src_idx[p] == 0);
                req_tail[p]            = (src_idx[p] == src_len[p] - 1);
                req_data[p*DW +: DW]   = mk_flit(p, src_len[p], src_idx[p], src_pkt[p]);
            end
        end
        if (force_orphan) begin
            req_valid[2] = 1'b1;
            req_head[2]  = 1'b0;
            req_tail[2]  = 1'b0;
        end
        #1;

        own       = m_owner;
        exp_ready = '0;
        if (own >= 0) exp_ready[own] = !nsu_busy;
        check_eq("req_ready", word_t'(req_ready), word_t'(exp_ready));
        hs = req_valid & req_ready;

        e_data = '0;
        e_head = 1'b0;
        e_tail = 1'b0;
        for (int p = 0; p < PN; p++) begin
            if (req_valid[p] && !req_head[p] && p != own) m_orphan = 1'b1;
        end
        if (own < 0) begin
            for (int k = 1; k <= PN; k++) begin
                win = (m_last + k) % PN;
                if (req_valid[win] && req_head[win]) begin
                    m_owner = win;
                    m_last  = win;
                    m_gid   = win;
                    break;
                end
            end
        end else if (req_valid[own] && !nsu_busy) begin
            e_data = {1'b1, req_data[own*DW +: DW]};
            e_head = req_head[own];
            e_tail = req_tail[own];
            m_cnt++;
            if (m_cnt >= FM + 2 && !req_tail[own]) m_overlong = 1'b1;
            if (req_tail[own]) begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        if (rst_drv) reset_model();

        @(negedge noc_clk);
        for (int p = 0; p < PN; p++) begin
            if (rst_drv) begin
                src_len[p] = 0;
                src_idx[p] = 0;
            end else if (hs[p]) begin
                if (src_idx[p] == src_len[p] - 1) begin
                    src_len[p] = 0;
                    src_idx[p] = 0;
                    src_pkt[p]++;
                end else begin
                    src_idx[p]++;
                end
            end
            if (pkt_rand && !rst_drv && src_len[p] == 0 && $urandom_range(1) == 0) begin
                src_len[p] = $urandom_range(6, 1);
            end
        end
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit done;
        int pending;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            pending = 0;
            for (int p = 0; p < PN; p++) pending += src_len[p];
            done = (pending == 0) && (m_owner < 0);
        end
        step();
        check_eq("drain_in_budget", word_t'(done), word_t'(1));
    endtask

    initial begin
        for (int p = 0; p < PN; p++) begin
            src_len[p] = 0;
            src_idx[p] = 0;
            src_pkt[p] = 0;
        end
        force_orphan = 1'b0;
        busy_mode    = 0;
        valid_rand   = 1'b0;
        pkt_rand     = 1'b0;
        rst_drv      = 1'b0;
        n_out        = 0;
        noc_rst      = 1'b1;
        nsu_busy     = 1'b0;
        req_valid    = '0;
        req_head     = '0;
        req_tail     = '0;
        req_data     = '0;
        reset_model();
        repeat (2) @(posedge noc_clk);
        @(negedge noc_clk);
        do_reset();
        do_reset();

        // Single long packet from port 0 at full rate.
        n_out = 0;
        src_len[0] = FM + 2;
        drain(60);
        check_eq("long_pkt_flits", word_t'(n_out), word_t'(FM + 2));

        // All four ports pending after reset: strict 0,1,2,3 order.
        do_reset();
        head_log.delete();
        n_out = 0;
        for (int p = 0; p < PN; p++) src_len[p] = 3;
        drain(60);
        check_eq("rr_pkt_count", word_t'(head_log.size()), word_t'(PN));
        for (int p = 0; p < PN && p < head_log.size(); p++) begin
            check_eq("rr_order", word_t'(head_log[p]), word_t'(p));
        end
        check_eq("rr_flits", word_t'(n_out), word_t'(3 * PN));

        // Five cycles of NSU backpressure in the middle of a body.
        do_reset();
        n_out = 0;
        src_len[0] = 10;
        repeat (5) step();
        busy_mode = 1;
        repeat (5) step();
        busy_mode = 0;
        drain(40);
        check_eq("busy_flits", word_t'(n_out), word_t'(10));

        // Port 2 offers a body flit while nobody owns the port.
        do_reset();
        n_out = 0;
        force_orphan = 1'b1;
        step();
        force_orphan = 1'b0;
        step();
        check_eq("orphan_sticky", word_t'(err_orphan), word_t'(1));
        check_eq("orphan_no_out", word_t'(n_out), word_t'(0));

        // Port 1 packet of 22 non-tail flits then a tail.
        do_reset();
        src_len[1] = FM + 7;
        drain(60);
        check_eq("overlong_sticky", word_t'(err_overlong), word_t'(1));

        // Reset while port 0 is on its fifth body flit.
        do_reset();
        src_len[0] = 10;
        for (int p = 1; p < PN; p++) src_len[p] = 3;
        for (int i = 0; i < 20 && src_idx[0] != 5; i++) step();
        check_eq("reached_body5", word_t'(src_idx[0]), word_t'(5));
        do_reset();
        for (int p = 0; p < PN; p++) src_len[p] = 2;
        step();
        step();
        check_eq("post_rst_grant", word_t'(grant_id), word_t'(0));
        drain(40);

        // Randomized traffic with random valid gaps and backpressure.
        do_reset();
        pkt_rand   = 1'b1;
        valid_rand = 1'b1;
        busy_mode  = 2;
        repeat (2000) step();
        pkt_rand = 1'b0;
        drain(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
